// File: rtl/ex_stage.sv
// Execute stage: operand select, single-cycle RV32I ALU, iterative RV32M mul/div,
// and the EX/MEM pipeline registers.
module ex_stage #(
  parameter int XLEN     = 32,
  parameter int MD_STEPS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            valid_ex,
  input  logic [XLEN-1:0] pc_ex,
  input  logic [XLEN-1:0] instr_ex,
  input  logic [XLEN-1:0] rs1_ex,
  input  logic [XLEN-1:0] rs2_ex,
  input  logic [XLEN-1:0] imm_ex,
  input  logic            op_a_sel,
  input  logic            op_b_sel,
  input  logic [4:0]      alu_op,
  output logic            stall_ex,
  output logic            valid_mem,
  output logic [XLEN-1:0] pc_mem,
  output logic [XLEN-1:0] instr_mem,
  output logic [XLEN-1:0] alu_mem,
  output logic [XLEN-1:0] rs2_mem
);

  localparam int CW = $clog2(MD_STEPS);
  localparam int SW = $clog2(XLEN);
  localparam logic [CW-1:0]   LAST    = CW'(MD_STEPS - 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, b_q, b_d, res_q, res_d;
  logic [2:0]      mop_q, mop_d;
  logic            negA_q, negA_d, negB_q, negB_d, special_q, special_d;
  logic            validMem_q, validMem_d;
  logic [XLEN-1:0] pcMem_q, pcMem_d, instrMem_q, instrMem_d;
  logic [XLEN-1:0] aluMem_q, aluMem_d, rs2Mem_q, rs2Mem_d;

  logic [XLEN-1:0] opA, opB, aluRes, absA, absB, specialRes;
  logic [SW-1:0]   shamt;
  logic            startM, aSigned, bSigned, negA, negB, special;

  assign opA    = op_a_sel ? pc_ex : rs1_ex;
  assign opB    = op_b_sel ? imm_ex : rs2_ex;
  assign shamt  = opB[SW-1:0];
  assign startM = (state_q == IDLE) && valid_ex && alu_op[4] && !flush;

  assign stall_ex  = (state_q == BUSY) || startM;
  assign valid_mem = validMem_q;
  assign pc_mem    = pcMem_q;
  assign instr_mem = instrMem_q;
  assign alu_mem   = aluMem_q;
  assign rs2_mem   = rs2Mem_q;

  always_comb begin
    aluRes = '0;
    case (alu_op)
      5'd0:  aluRes = opA + opB;
      5'd1:  aluRes = opA - opB;
      5'd2:  aluRes = opA << shamt;
      5'd3:  aluRes = {{(XLEN-1){1'b0}}, $signed(opA) < $signed(opB)};
      5'd4:  aluRes = {{(XLEN-1){1'b0}}, opA < opB};
      5'd5:  aluRes = opA ^ opB;
      5'd6:  aluRes = opA >> shamt;
      5'd7:  aluRes = $unsigned($signed(opA) >>> shamt);
      5'd8:  aluRes = opA | opB;
      5'd9:  aluRes = opA & opB;
      5'd10: aluRes = opB;
      default: aluRes = '0;
    endcase
  end

  // Codes 24..31 still take the M path but produce 0, so they ride the special-result flag.
  always_comb begin
    aSigned    = (alu_op[2:0] == 3'd1) || (alu_op[2:0] == 3'd2) ||
                 (alu_op[2:0] == 3'd4) || (alu_op[2:0] == 3'd6);
    bSigned    = (alu_op[2:0] == 3'd1) || (alu_op[2:0] == 3'd4) || (alu_op[2:0] == 3'd6);
    negA       = aSigned && opA[XLEN-1];
    negB       = bSigned && opB[XLEN-1];
    absA       = negA ? -opA : opA;
    absB       = negB ? -opB : opB;
    special    = alu_op[3] || (alu_op[2] && ((opB == '0) ||
                 (bSigned && (opA == MIN_NEG) && (opB == '1))));
    specialRes = '0;
    if (alu_op[3])         specialRes = '0;
    else if (opB == '0)    specialRes = alu_op[1] ? opA : '1;
    else                   specialRes = alu_op[1] ? '0 : MIN_NEG;
  end

  logic [XLEN:0]     mulSum, divShift;
  logic [XLEN-1:0]   divDiff, stepHi, stepLo, quo, rem, finalRes;
  logic [2*XLEN-1:0] prod, prodS;
  logic              divGe;

  // hi/lo hold {partial product, multiplier} for mul and {remainder, dividend} for div.
  always_comb begin
    mulSum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    divShift = {hi_q, lo_q[XLEN-1]};
    divGe    = divShift >= {1'b0, b_q};
    divDiff  = divShift[XLEN-1:0] - b_q;
    if (mop_q[2]) begin
      stepHi = divGe ? divDiff : divShift[XLEN-1:0];
      stepLo = {lo_q[XLEN-2:0], divGe};
    end else begin
      stepHi = mulSum[XLEN:1];
      stepLo = {mulSum[0], lo_q[XLEN-1:1]};
    end
    prod  = {stepHi, stepLo};
    prodS = (negA_q ^ negB_q) ? -prod : prod;
    quo   = (negA_q ^ negB_q) ? -stepLo : stepLo;
    rem   = negA_q ? -stepHi : stepHi;
    case (mop_q)
      3'd0:             finalRes = prodS[XLEN-1:0];
      3'd1, 3'd2, 3'd3: finalRes = prodS[2*XLEN-1:XLEN];
      3'd4, 3'd5:       finalRes = quo;
      default:          finalRes = rem;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    b_d        = b_q;
    res_d      = res_q;
    mop_d      = mop_q;
    negA_d     = negA_q;
    negB_d     = negB_q;
    special_d  = special_q;
    validMem_d = validMem_q;
    pcMem_d    = pcMem_q;
    instrMem_d = instrMem_q;
    aluMem_d   = aluMem_q;
    rs2Mem_d   = rs2Mem_q;
    case (state_q)
      IDLE: begin
        if (startM) begin
          state_d    = BUSY;
          cnt_d      = '0;
          hi_d       = '0;
          lo_d       = absA;
          b_d        = absB;
          mop_d      = alu_op[2:0];
          negA_d     = negA;
          negB_d     = negB;
          special_d  = special;
          res_d      = specialRes;
          validMem_d = 1'b0;
        end else begin
          validMem_d = valid_ex && !flush;
          pcMem_d    = pc_ex;
          instrMem_d = instr_ex;
          aluMem_d   = aluRes;
          rs2Mem_d   = rs2_ex;
        end
      end
      BUSY: begin
        validMem_d = 1'b0;
        hi_d       = stepHi;
        lo_d       = stepLo;
        cnt_d      = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
          if (!special_q) res_d = finalRes;
        end
      end
      DONE: begin
        state_d    = IDLE;
        validMem_d = 1'b1;
        pcMem_d    = pc_ex;
        instrMem_d = instr_ex;
        aluMem_d   = res_q;
        rs2Mem_d   = rs2_ex;
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d    = IDLE;
      cnt_d      = '0;
      validMem_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      b_q        <= '0;
      res_q      <= '0;
      mop_q      <= '0;
      negA_q     <= 1'b0;
      negB_q     <= 1'b0;
      special_q  <= 1'b0;
      validMem_q <= 1'b0;
      pcMem_q    <= '0;
      instrMem_q <= '0;
      aluMem_q   <= '0;
      rs2Mem_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      b_q        <= b_d;
      res_q      <= res_d;
      mop_q      <= mop_d;
      negA_q     <= negA_d;
      negB_q     <= negB_d;
      special_q  <= special_d;
      validMem_q <= validMem_d;
      pcMem_q    <= pcMem_d;
      instrMem_q <= instrMem_d;
      aluMem_q   <= aluMem_d;
      rs2Mem_q   <= rs2Mem_d;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: reference ALU model feeds a scoreboard queue that is
// drained when results land in the EX/MEM registers.
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        rst, flush, valid_ex, op_a_sel, op_b_sel;
  logic [31:0] pc_ex, instr_ex, rs1_ex, rs2_ex, imm_ex;
  logic [4:0]  alu_op;
  logic        stall_ex, valid_mem;
  logic [31:0] pc_mem, instr_mem, alu_mem, rs2_mem;

  typedef struct {
    logic [31:0] alu;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] rs2;
  } exp_t;

  exp_t sbQ[$];
  int   passCnt  = 0;
  int   totalCnt = 0;
  logic [31:0] pcNext = 32'h0000_1000;

  ex_stage #(.XLEN(32), .MD_STEPS(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .valid_ex(valid_ex),
    .pc_ex(pc_ex), .instr_ex(instr_ex), .rs1_ex(rs1_ex), .rs2_ex(rs2_ex),
    .imm_ex(imm_ex), .op_a_sel(op_a_sel), .op_b_sel(op_b_sel), .alu_op(alu_op),
    .stall_ex(stall_ex), .valid_mem(valid_mem), .pc_mem(pc_mem),
    .instr_mem(instr_mem), .alu_mem(alu_mem), .rs2_mem(rs2_mem)
  );

  always #5 clk = ~clk;

  // Independent reference using native 64-bit and signed arithmetic.
  function automatic logic [31:0] refAlu(logic [4:0] op, logic [31:0] a, logic [31:0] b);
    longint          sa = longint'($signed(a));
    longint          sb = longint'($signed(b));
    longint unsigned ua = {32'h0, a};
    longint unsigned ub = {32'h0, b};
    int              ia = int'(a);
    int              ib = int'(b);
    logic [63:0]     p;
    logic            ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      5'd0:  return a + b;
      5'd1:  return a - b;
      5'd2:  return a << b[4:0];
      5'd3:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      5'd4:  return (a < b) ? 32'd1 : 32'd0;
      5'd5:  return a ^ b;
      5'd6:  return a >> b[4:0];
      5'd7:  return $unsigned($signed(a) >>> b[4:0]);
      5'd8:  return a | b;
      5'd9:  return a & b;
      5'd10: return b;
      5'd16: begin p = ua * ub; return p[31:0]; end
      5'd17: begin p = sa * sb; return p[63:32]; end
      5'd18: begin p = sa * longint'(ub); return p[63:32]; end
      5'd19: begin p = ua * ub; return p[63:32]; end
      5'd20: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(ia / ib);
      5'd21: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      5'd22: return (b == 0) ? a : ovf ? 32'h0 : 32'(ia % ib);
      5'd23: return (b == 0) ? a : a % b;
      default: return 32'h0;
    endcase
  endfunction

  task automatic checkVal(string tag, logic [31:0] obs, logic [31:0] expv);
    totalCnt++;
    assert (obs === expv) passCnt++;
    else $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
  endtask

  task automatic applyStimulus(logic [4:0] op, logic aSel, logic bSel, logic [31:0] rs1,
                               logic [31:0] rs2, logic [31:0] imm, bit push);
    exp_t e;
    pcNext   = pcNext + 32'd4;
    valid_ex = 1'b1;
    alu_op   = op;
    op_a_sel = aSel;
    op_b_sel = bSel;
    rs1_ex   = rs1;
    rs2_ex   = rs2;
    imm_ex   = imm;
    pc_ex    = pcNext;
    instr_ex = {pcNext[15:0], 11'h0, op};
    e.alu    = refAlu(op, aSel ? pcNext : rs1, bSel ? imm : rs2);
    e.pc     = pc_ex;
    e.instr  = instr_ex;
    e.rs2    = rs2;
    if (push) sbQ.push_back(e);
  endtask

  // Counts stall cycles at negedges, bounded, then steps to #1 after the capturing edge.
  task automatic awaitEdge(int expStall, string tag);
    int n = 0;
    bit seenIdle = 1'b0;
    bit busyValid = 1'b0;
    for (int i = 0; i < 60 && !seenIdle; i++) begin
      @(negedge clk);
      if (stall_ex) begin
        if (n > 0 && valid_mem) busyValid = 1'b1;
        n++;
      end else begin
        seenIdle = 1'b1;
      end
    end
    checkVal({tag, "_stallcycles"}, 32'(n), 32'(expStall));
    if (expStall > 0) checkVal({tag, "_validduringbusy"}, {31'h0, busyValid}, 32'h0);
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(string tag);
    exp_t e;
    if (sbQ.size() == 0) begin
      checkVal({tag, "_sbempty"}, 32'h1, 32'h0);
    end else begin
      e = sbQ.pop_front();
      checkVal({tag, "_valid"}, {31'h0, valid_mem}, 32'h1);
      checkVal({tag, "_alu"},   alu_mem,   e.alu);
      checkVal({tag, "_pc"},    pc_mem,    e.pc);
      checkVal({tag, "_instr"}, instr_mem, e.instr);
      checkVal({tag, "_rs2"},   rs2_mem,   e.rs2);
    end
  endtask

  task automatic bubble();
    valid_ex = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic runOp(logic [4:0] op, logic aSel, logic bSel, logic [31:0] rs1,
                       logic [31:0] rs2, logic [31:0] imm, int expStall, string tag);
    applyStimulus(op, aSel, bSel, rs1, rs2, imm, 1'b1);
    awaitEdge(expStall, tag);
    checkOutput(tag);
    bubble();
  endtask

  task automatic checkAllZero(string tag);
    checkVal({tag, "_valid"}, {31'h0, valid_mem}, 32'h0);
    checkVal({tag, "_stall"}, {31'h0, stall_ex},  32'h0);
    checkVal({tag, "_pc"},    pc_mem,    32'h0);
    checkVal({tag, "_instr"}, instr_mem, 32'h0);
    checkVal({tag, "_alu"},   alu_mem,   32'h0);
    checkVal({tag, "_rs2"},   rs2_mem,   32'h0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; valid_ex = 1'b0; op_a_sel = 1'b0; op_b_sel = 1'b0;
    alu_op = 5'd0; pc_ex = '0; instr_ex = '0; rs1_ex = '0; rs2_ex = '0; imm_ex = '0;
    repeat (2) @(posedge clk);
    #1;
    checkAllZero("reset");
    rst = 1'b0;

    runOp(5'd0,  1'b0, 1'b1, 32'd5,          32'h11,      32'hFFFF_FFFD, 0, "add");
    runOp(5'd1,  1'b1, 1'b0, 32'h0,          32'h10,      32'h0,         0, "sub_pc");
    runOp(5'd7,  1'b0, 1'b1, 32'hF000_0000,  32'h0,       32'd4,         0, "sra");
    runOp(5'd6,  1'b0, 1'b1, 32'hF000_0000,  32'h0,       32'h24,        0, "srl");
    runOp(5'd2,  1'b0, 1'b0, 32'h0000_0003,  32'd31,      32'h0,         0, "sll");
    runOp(5'd3,  1'b0, 1'b0, 32'hFFFF_FFFF,  32'd1,       32'h0,         0, "slt");
    runOp(5'd4,  1'b0, 1'b0, 32'hFFFF_FFFF,  32'd1,       32'h0,         0, "sltu");
    runOp(5'd5,  1'b0, 1'b0, 32'hA5A5_0F0F,  32'hFFFF_0000, 32'h0,       0, "xor");
    runOp(5'd9,  1'b0, 1'b1, 32'hA5A5_0F0F,  32'h0,       32'h00FF_FF00, 0, "and");
    runOp(5'd8,  1'b0, 1'b0, 32'h1200_0034,  32'h0056_7800, 32'h0,       0, "or");
    runOp(5'd10, 1'b0, 1'b1, 32'h1,          32'h2,       32'hCAFE_F00D, 0, "passb");
    runOp(5'd12, 1'b0, 1'b0, 32'h1234,       32'h5678,    32'h0,         0, "undef");

    runOp(5'd20, 1'b0, 1'b0, 32'hFFFF_FFF9,  32'd2,        32'h0, 33, "div_neg");
    runOp(5'd22, 1'b0, 1'b0, 32'hFFFF_FFF9,  32'd2,        32'h0, 33, "rem_neg");
    runOp(5'd21, 1'b0, 1'b0, 32'h0000_1234,  32'd0,        32'h0, 33, "divu_zero");
    runOp(5'd23, 1'b0, 1'b0, 32'd9,          32'd0,        32'h0, 33, "remu_zero");
    runOp(5'd20, 1'b0, 1'b0, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0, 33, "div_ovf");
    runOp(5'd22, 1'b0, 1'b0, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0, 33, "rem_ovf");
    runOp(5'd20, 1'b0, 1'b0, 32'hFFFF_FFF9,  32'd0,        32'h0, 33, "div_zero_neg");
    runOp(5'd21, 1'b0, 1'b0, 32'd100,        32'd7,        32'h0, 33, "divu");
    runOp(5'd23, 1'b0, 1'b0, 32'd100,        32'd7,        32'h0, 33, "remu");
    runOp(5'd17, 1'b0, 1'b0, 32'h8000_0000,  32'h8000_0000, 32'h0, 33, "mulh");
    runOp(5'd19, 1'b0, 1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0, 33, "mulhu");
    runOp(5'd16, 1'b0, 1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0, 33, "mul");
    runOp(5'd18, 1'b0, 1'b0, 32'hFFFF_FFFF,  32'd2,        32'h0, 33, "mulhsu");
    runOp(5'd16, 1'b0, 1'b1, 32'hFFFF_FFF9,  32'h0,        32'd6, 33, "mul_imm");

    // Flush the divider at cnt = 10; no result may appear.
    applyStimulus(5'd21, 1'b0, 1'b0, 32'd1000, 32'd3, 32'h0, 1'b0);
    repeat (11) @(posedge clk);
    #1;
    flush = 1'b1;
    valid_ex = 1'b0;
    @(posedge clk);
    #1;
    flush = 1'b0;
    checkVal("flush_busy_stall", {31'h0, stall_ex},  32'h0);
    checkVal("flush_busy_valid", {31'h0, valid_mem}, 32'h0);
    runOp(5'd0, 1'b0, 1'b0, 32'd40, 32'd2, 32'h0, 0, "add_after_flush");

    // Flush in IDLE turns a base op into a bubble.
    applyStimulus(5'd0, 1'b0, 1'b0, 32'd1, 32'd1, 32'h0, 1'b0);
    flush = 1'b1;
    @(posedge clk);
    #1;
    bubble();
    checkVal("flush_idle_valid", {31'h0, valid_mem}, 32'h0);

    // Leave nonzero data in the EX/MEM registers, then reset mid-BUSY.
    runOp(5'd5, 1'b0, 1'b0, 32'h1111_1111, 32'h2222_2222, 32'h0, 0, "xor_prereset");
    applyStimulus(5'd16, 1'b0, 1'b0, 32'd7, 32'd9, 32'h0, 1'b0);
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    valid_ex = 1'b0;
    @(posedge clk);
    #1;
    checkAllZero("rst_busy");
    rst = 1'b0;

    // Back-to-back MUL then ADD: ADD is captured one edge after the MUL's DONE edge.
    applyStimulus(5'd16, 1'b0, 1'b0, 32'h0001_0003, 32'h0002_0005, 32'h0, 1'b1);
    awaitEdge(33, "b2b_mul");
    checkOutput("b2b_mul");
    applyStimulus(5'd0, 1'b1, 1'b1, 32'h0, 32'h77, 32'd8, 1'b1);
    awaitEdge(0, "b2b_add");
    checkOutput("b2b_add");
    bubble();
    @(posedge clk);
    #1;
    checkVal("bubble_after_b2b", {31'h0, valid_mem}, 32'h0);
    checkVal("sb_drained", 32'(sbQ.size()), 32'h0);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
